// File: rtl/mem_access_pkg.sv
// Shared encodings for the byte-granular memory access controller:
// MemOp width/sign fields, FSM states and small size/split helpers.
package mem_access_pkg;

    typedef enum logic [1:0] {
        W_WORD     = 2'b00,
        W_BYTE     = 2'b01,
        W_HALF     = 2'b10,
        W_WORD_ALT = 2'b11
    } width_e;

    localparam int SIGN_BIT = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        CAP0,
        RD1,
        CAP1,
        WR0,
        WR1,
        DONE
    } state_e;

    function automatic logic [2:0] size_of(input logic [1:0] w);
        case (w)
            W_BYTE:  return 3'd1;
            W_HALF:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // An access straddles two RAM words when its last byte lands past offset 3.
    function automatic logic is_split(input logic [1:0] off, input logic [1:0] w);
        return ({1'b0, off} + size_of(w)) > 3'd4;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data path: extracts/extends load data from a two-word window
// and merges store bytes into that window.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [31:0] buf_lo_i,
    input  logic [31:0] buf_hi_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_lo_o,
    output logic [31:0] store_hi_o
);

    logic [63:0] shifted;
    logic [63:0] merged;
    logic [2:0]  size;

    always_comb begin
        size    = size_of(op_i[1:0]);
        shifted = {buf_hi_i, buf_lo_i} >> {off_i, 3'b000};
        load_o  = shifted[31:0];
        case (op_i[1:0])
            W_BYTE:  load_o = op_i[SIGN_BIT] ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'h0, shifted[7:0]};
            W_HALF:  load_o = op_i[SIGN_BIT] ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
            default: load_o = shifted[31:0];
        endcase

        merged = {buf_hi_i, buf_lo_i};
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < size) begin
                merged[8*(int'(off_i) + i) +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    assign store_lo_o = merged[31:0];
    assign store_hi_o = merged[63:32];

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-addressed load/store front end for a word-wide RAM with one-cycle reads.
// Unaligned accesses are split into two word reads and, for stores, two word writes.
//
// state | meaning
// IDLE  | ready, waiting for req
// RD0   | present low word address
// CAP0  | capture low word into buf0
// RD1   | present high word address (split only)
// CAP1  | capture high word into buf1
// WR0   | write merged low word
// WR1   | write merged high word (split only)
// DONE  | one-cycle completion pulse
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ready,
    input  logic              we,
    input  logic [2:0]        MemOp,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         buf0_q, buf0_d, buf1_q, buf1_d;
    logic                ready_q, done_q, mem_we_q;
    logic [31:0]         rdata_q, mem_wdata_q;
    logic [ADDR_W-3:0]   mem_addr_q;
    logic [ADDR_W-3:0]   w0, w1;
    logic                split, word_store;
    logic [31:0]         load_data, store_lo, store_hi;

    // Next-cycle views of the latched request and buffers, so registered
    // outputs can use a word in the same edge that captures it.
    always_comb begin
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == IDLE && req) begin
            we_d    = we;
            op_d    = MemOp;
            addr_d  = addr;
            wdata_d = wdata;
        end
        buf0_d = (state_q == CAP0) ? mem_rdata : buf0_q;
        buf1_d = (state_q == CAP1) ? mem_rdata : buf1_q;
    end

    assign w0         = addr_d[ADDR_W-1:2];
    assign w1         = w0 + (ADDR_W-2)'(1);
    assign split      = is_split(addr_d[1:0], op_d[1:0]);
    assign word_store = we_d && (size_of(op_d[1:0]) == 3'd4) && (addr_d[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = word_store ? WR0 : RD0;
            RD0:     state_d = CAP0;
            CAP0:    state_d = split ? RD1 : (we_q ? WR0 : DONE);
            RD1:     state_d = CAP1;
            CAP1:    state_d = we_q ? WR0 : DONE;
            WR0:     state_d = split ? WR1 : DONE;
            WR1:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mem_align u_align (
        .buf_lo_i   (buf0_d),
        .buf_hi_i   (buf1_d),
        .off_i      (addr_d[1:0]),
        .op_i       (op_d),
        .wdata_i    (wdata_d),
        .load_o     (load_data),
        .store_lo_o (store_lo),
        .store_hi_o (store_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            ready_q    <= (state_d == IDLE);
            done_q     <= (state_d == DONE);
            mem_we_q   <= (state_d == WR0) || (state_d == WR1);
            mem_addr_q <= (state_d inside {RD1, CAP1, WR1}) ? w1 : w0;
            if (state_d == WR0) begin
                mem_wdata_q <= store_lo;
            end else if (state_d == WR1) begin
                mem_wdata_q <= store_hi;
            end
            if (state_d == DONE && !we_d) begin
                rdata_q <= load_data;
            end
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, giving the byte-address width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1 bit: CPU access request.
REQ-005 SHALL have port ready, output, 1 bit: controller idle; request accepted on req & ready.
REQ-006 SHALL have port we, input, 1 bit: 1 = store, 0 = load; sampled at accept.
REQ-007 SHALL have port MemOp, input, 3 bits: [1:0] width (00 word, 01 byte, 10 half, 11 treated as word); [2] sign-extend loads, ignored on stores.
REQ-008 SHALL have port addr, input, ADDR_W bits: byte address, little-endian, any alignment.
REQ-009 SHALL have port wdata, input, 32 bits: store data, low-order bytes used.
REQ-010 SHALL have port rdata, output, 32 bits: extended load result.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port mem_addr, output, ADDR_W-2 bits: word address to the word RAM.
REQ-013 SHALL have port mem_we, output, 1 bit: RAM word write enable.
REQ-014 SHALL have port mem_wdata, output, 32 bits: RAM write word.
REQ-015 SHALL have port mem_rdata, input, 32 bits: RAM read word, valid one cycle after mem_addr is presented with mem_we=0.

Function
REQ-016 SHALL use states IDLE, RD0, CAP0, RD1, CAP1, WR0, WR1, DONE; ready=1 only in IDLE.
REQ-017 SHALL latch we, MemOp, addr, wdata on accept and ignore req outside IDLE.
REQ-018 SHALL compute w0=addr[ADDR_W-1:2], off=addr[1:0], w1=w0+1 modulo 2^(ADDR_W-2) (top word wraps to 0).
REQ-019 SHALL flag split when off+size>4 (size 1/2/4 bytes).
REQ-020 SHALL sequence: IDLE->RD0->CAP0->(split ? RD1->CAP1) -> load: DONE; store: WR0->(split ? WR1)->DONE; DONE->IDLE.
REQ-021 SHALL skip reads for an aligned word store: IDLE->WR0->DONE.
REQ-022 SHALL drive mem_addr=w0 in RD0/CAP0/WR0 and w1 in RD1/CAP1/WR1; mem_we=1 only in WR0/WR1.
REQ-023 SHALL capture mem_rdata into buf0 in CAP0, buf1 in CAP1.
REQ-024 SHALL form loads from {buf1,buf0} >> (8*off), truncated to width, zero- or sign-extended per MemOp[2].
REQ-025 SHALL form stores by replacing bytes off..off+size-1 of {buf1,buf0} with wdata low bytes; WR0 writes the low word, WR1 the high.
REQ-026 SHALL assert done for exactly the DONE cycle; rdata updates in DONE and holds until the next load's DONE.
REQ-027 SHALL meet latency from accept cycle T: aligned load done T+3; split load T+5; aligned word store T+2; aligned sub-word store T+4; split store T+7.
REQ-028 SHALL accept a new req in the IDLE cycle directly following DONE (no extra bubble).

Reset
REQ-029 SHALL on rst go to IDLE with ready=1, done=0, mem_we=0, rdata=0, mem_addr=0, mem_wdata=0, buffers 0.
REQ-030 SHALL abort any access on rst mid-operation, with no mem_we asserted in the cycle following the reset edge and no done pulse.

Structure
REQ-031 SHALL place MemOp width/sign encodings and the state enum in shared package mem_access_pkg.
REQ-032 SHALL place load extract/extend and store byte-merge in combinational sub-module mem_align.

Verification (RAM model: 1-cycle read; word0=0x44332211, word1=0x88776655)
REQ-033 SHALL check load word addr 0x0000, MemOp 000 -> rdata 0x44332211, done at T+3.
REQ-034 SHALL check load byte signed addr 0x0007, MemOp 101 -> rdata 0xFFFFFF88; MemOp 001 -> 0x00000088.
REQ-035 SHALL check split load half addr 0x0003, MemOp 110 -> rdata 0x00005544, done at T+5.
REQ-036 SHALL check split store word 0xAABBCCDD at addr 0x0002 -> word0=0xCCDD2211, word1=0x8877AABB, done at T+7.
REQ-037 SHALL check split load word at addr 0xFFFE -> second read at word address 0x0000 (wrap).
REQ-038 SHALL check rst asserted in WR0 of a split store -> next cycle IDLE, ready=1, mem_we=0, word1 unchanged, no done.
